mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported backing memory between the fetch requester (IF) and the
//  load/store requester (LSU). Arbitrates requests, holds one transaction in flight,
//  and routes each response back to the requester that issued it. Sits below
//  if_stage/lsu and replaces separate imem/dmem ports in unified-memory builds.
//  Supports IF flush (branch redirect) by suppressing stale fetch responses.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width (strobe width = DW/8)
//  LSU_PRIO    1   1: LSU wins ties (fixed priority + starvation guard); 0: round-robin
//  MAX_STARVE  4   fixed-priority mode: max consecutive LSU grants while IF waits (>=1)
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous reset, active-high
//  i_if_flush       in   1     discard pending/in-flight IF fetch
//  if_req_valid     in   1     IF request valid
//  if_req_ready     out  1     IF request accepted this cycle
//  if_req_addr      in   AW    IF fetch address (read-only requester)
//  if_resp_valid    out  1     IF response valid (1 cycle)
//  if_resp_rdata    out  DW    IF response data
//  lsu_req_valid    in   1     LSU request valid
//  lsu_req_ready    out  1     LSU request accepted this cycle
//  lsu_req_addr     in   AW    LSU address
//  lsu_req_we       in   1     1 = store
//  lsu_req_wdata    in   DW    store data
//  lsu_req_wstrb    in   DW/8  byte strobes
//  lsu_resp_valid   out  1     LSU response valid (loads and stores, 1 cycle)
//  lsu_resp_rdata   out  DW    load data (0 for stores)
//  mem_req_valid    out  1     request to memory
//  mem_req_ready    in   1     memory accepts request
//  mem_req_addr     out  AW    / mem_req_we out 1 / mem_req_wdata out DW / mem_req_wstrb out DW/8
//  mem_resp_valid   in   1     memory response (exactly one per accepted request)
//  mem_resp_rdata   in   DW    memory response data
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> WAIT -> IDLE. Exactly one transaction outstanding.
//  - IDLE: if any eligible req_valid, pick winner, pulse its req_ready (same cycle,
//    combinational from valids/state), latch addr/we/wdata/wstrb + owner; -> ISSUE.
//    IF is ineligible in any cycle i_if_flush=1. Both ready never high together.
//  - Arbitration: LSU_PRIO=1: LSU wins unless starve_cnt==MAX_STARVE and IF valid;
//    starve_cnt++ on LSU grant with IF valid, clears on IF grant or IF not valid.
//    LSU_PRIO=0: alternate on contention; last-granted pointer flips per grant.
//  - ISSUE: mem_req_valid=1 with latched fields (stable) until mem_req_ready; -> WAIT.
//    If mem_req_ready && mem_resp_valid same cycle, treat as response and -> IDLE.
//  - WAIT: on mem_resp_valid, register response to owner: {owner}_resp_valid=1 next
//    cycle with rdata (lsu rdata forced 0 for stores); -> IDLE. Back-to-back: new grant
//    allowed in the IDLE cycle right after the response cycle.
//  - Latency (no mem stall, 1-cycle mem): req accepted C0, mem_req C1, mem_resp C2,
//    resp_valid C3.
//  - Flush: i_if_flush while owner=IF in ISSUE/WAIT sets drop flag; transaction still
//    completes on memory side, if_resp_valid suppressed; flag clears on return to IDLE.
//    Flush in same cycle as mem_resp_valid also suppresses. Flush never affects LSU.
//  - IF writes impossible: mem_req_we=0, wstrb=0 for IF-owned transactions.
//  - mem_resp_valid in IDLE/ISSUE-without-ready: ignored (protocol error, no state change).
//  - Reset: all *_ready, *_resp_valid, mem_req_valid = 0; data outputs 0; state IDLE;
//    starve_cnt=0, RR pointer=IF, drop flag=0. Reset mid-transaction abandons it;
//    memory model is reset together with this block.
// TESTING
//  - Single IF read addr 0x100, mem returns 0xDEADBEEF -> if_resp_valid C3, rdata
//    0xDEADBEEF, lsu_resp_valid never set.
//  - LSU store addr 0x40 wdata 0x12345678 wstrb 0xF -> mem_req_we=1, fields match;
//    lsu_resp_valid=1, rdata=0.
//  - LSU_PRIO=1, both valid continuously -> grants L,L,L,L,IF repeating (MAX_STARVE=4);
//    LSU_PRIO=0 -> strict alternation.
//  - IF fetch in WAIT, i_if_flush pulsed, mem_req_ready held 0 for 3 cycles -> mem
//    transaction completes, no if_resp_valid; next IF request serviced normally.
//  - rst asserted while in ISSUE -> next cycle mem_req_valid=0, all ready/resp 0, IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and LSU loads/stores onto one single-ported memory,
// one transaction in flight, with responses routed back to the issuing requester.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int LSU_PRIO   = 1,
   parameter int MAX_STARVE = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_if_flush,
   input  logic            if_req_valid,
   output logic            if_req_ready,
   input  logic [AW-1:0]   if_req_addr,
   output logic            if_resp_valid,
   output logic [DW-1:0]   if_resp_rdata,
   input  logic            lsu_req_valid,
   output logic            lsu_req_ready,
   input  logic [AW-1:0]   lsu_req_addr,
   input  logic            lsu_req_we,
   input  logic [DW-1:0]   lsu_req_wdata,
   input  logic [DW/8-1:0] lsu_req_wstrb,
   output logic            lsu_resp_valid,
   output logic [DW-1:0]   lsu_resp_rdata,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [AW-1:0]   mem_req_addr,
   output logic            mem_req_we,
   output logic [DW-1:0]   mem_req_wdata,
   output logic [DW/8-1:0] mem_req_wstrb,
   input  logic            mem_resp_valid,
   input  logic [DW-1:0]   mem_resp_rdata
);

   localparam int SW = DW/8;
   localparam int CW = $clog2(MAX_STARVE + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          owner_q, owner_d;   // 1 = LSU owns the transaction
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [SW-1:0] wstrb_q, wstrb_d;
   logic          drop_q, drop_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          rr_q, rr_d;         // last granted, 1 = LSU
   logic          if_rv_q, if_rv_d;
   logic          lsu_rv_q, lsu_rv_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] lsu_rdata_q, lsu_rdata_d;

   logic if_elig, idle, pick_lsu, gnt_if, gnt_lsu, resp_take;

   assign if_elig = if_req_valid && !i_if_flush;
   assign idle    = (state_q == S_IDLE) && !rst;

   always_comb begin
      pick_lsu = 1'b0;
      if (LSU_PRIO != 0)
         pick_lsu = lsu_req_valid && !(if_elig && (starve_q == CW'(MAX_STARVE)));
      else
         pick_lsu = lsu_req_valid && (!if_elig || !rr_q);
   end

   assign gnt_lsu = idle && pick_lsu;
   assign gnt_if  = idle && if_elig && !pick_lsu;

   // A response arriving together with the request handshake completes it directly.
   assign resp_take = mem_resp_valid &&
                      ((state_q == S_WAIT) || ((state_q == S_ISSUE) && mem_req_ready));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      drop_d      = drop_q;
      starve_d    = starve_q;
      rr_d        = rr_q;
      if_rv_d     = 1'b0;
      lsu_rv_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      lsu_rdata_d = lsu_rdata_q;
      case (state_q)
         S_IDLE: begin
            drop_d = 1'b0;
            if (gnt_if || gnt_lsu) begin
               state_d = S_ISSUE;
               owner_d = gnt_lsu;
               rr_d    = gnt_lsu;
               addr_d  = gnt_lsu ? lsu_req_addr : if_req_addr;
               we_d    = gnt_lsu && lsu_req_we;
               wdata_d = gnt_lsu ? lsu_req_wdata : '0;
               wstrb_d = gnt_lsu ? lsu_req_wstrb : '0;
            end
            if (gnt_lsu && if_elig)
               starve_d = starve_q + CW'(1);
            else if (gnt_if || !if_elig)
               starve_d = '0;
         end
         S_ISSUE: begin
            if (mem_req_ready)
               state_d = mem_resp_valid ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (mem_resp_valid)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if ((state_q != S_IDLE) && !owner_q && i_if_flush)
         drop_d = 1'b1;
      if (resp_take) begin
         drop_d = 1'b0;
         if (owner_q) begin
            lsu_rv_d    = 1'b1;
            lsu_rdata_d = we_q ? '0 : mem_resp_rdata;
         end else if (!(drop_q || i_if_flush)) begin
            if_rv_d    = 1'b1;
            if_rdata_d = mem_resp_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         drop_q      <= 1'b0;
         starve_q    <= '0;
         rr_q        <= 1'b0;
         if_rv_q     <= 1'b0;
         lsu_rv_q    <= 1'b0;
         if_rdata_q  <= '0;
         lsu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         drop_q      <= drop_d;
         starve_q    <= starve_d;
         rr_q        <= rr_d;
         if_rv_q     <= if_rv_d;
         lsu_rv_q    <= lsu_rv_d;
         if_rdata_q  <= if_rdata_d;
         lsu_rdata_q <= lsu_rdata_d;
      end
   end

   assign if_req_ready   = gnt_if;
   assign lsu_req_ready  = gnt_lsu;
   assign if_resp_valid  = if_rv_q;
   assign if_resp_rdata  = if_rdata_q;
   assign lsu_resp_valid = lsu_rv_q;
   assign lsu_resp_rdata = lsu_rdata_q;
   assign mem_req_valid  = (state_q == S_ISSUE);
   assign mem_req_addr   = addr_q;
   assign mem_req_we     = we_q;
   assign mem_req_wdata  = wdata_q;
   assign mem_req_wstrb  = wstrb_q;

endmodule
